// File: rtl/shft_seq_ctl.sv
// shft_seq_ctl - parametrised load/shift burst engine.
//
// Loads a WIDTH-bit word in parallel, then shifts it one bit per clock for a
// programmable number of cycles. The shift can go left or right, with one of
// four fill modes. A busy/done handshake brackets each burst. The last bit
// shifted out is held in a register on cout.
//
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset
//   load  - parallel load strobe (beats start; aborts a running burst)
//   LD    - parallel load data
//   start - begin a burst of amt shifts (honoured only when idle)
//   dir   - 1 = shift right (toward bit 0), 0 = shift left
//   mode  - fill: 00 logical, 01 arithmetic, 10 rotate, 11 serial-in (sin)
//   amt   - number of single-bit shifts in the burst
//   sin   - serial fill bit for mode 11
//   q     - register contents
//   cout  - last bit shifted out
//   busy  - burst in progress
//   done  - one-cycle pulse after a burst completes

module shft_seq_ctl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] LD,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             dir_r, dir_nxt;
  logic [1:0]       mode_r, mode_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             cout_nxt;
  logic             done_nxt;

  // Single-step shift datapath, driven by the burst's latched dir/mode.
  logic             out_bit;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    out_bit = dir_r ? q[0] : q[WIDTH-1];
    case (mode_r)
      2'b00:   fill = 1'b0;
      2'b01:   fill = dir_r ? q[WIDTH-1] : 1'b0;  // sign-extend only going right
      2'b10:   fill = out_bit;
      default: fill = sin;
    endcase
    shifted = dir_r ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    dir_nxt   = dir_r;
    mode_nxt  = mode_r;
    q_nxt     = q;
    cout_nxt  = cout;
    done_nxt  = 1'b0;

    if (load) begin
      // A load wins in either state: it also aborts a burst, with no done.
      q_nxt     = LD;
      rem_nxt   = '0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (amt != '0) begin
              dir_nxt   = dir;
              mode_nxt  = mode;
              rem_nxt   = amt;
              state_nxt = SHIFT;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        SHIFT: begin
          q_nxt    = shifted;
          cout_nxt = out_bit;
          rem_nxt  = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      rem    <= '0;
      dir_r  <= 1'b0;
      mode_r <= 2'b00;
      q      <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      dir_r  <= dir_nxt;
      mode_r <= mode_nxt;
      q      <= q_nxt;
      cout   <= cout_nxt;
      done   <= done_nxt;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shft_seq_ctl.sv
// tb_shft_seq_ctl - self-checking bench for shft_seq_ctl (WIDTH=8).
// Expected burst results are computed by a behavioural model when the burst
// is started, pushed to a scoreboard, and popped when done is seen.

module tb_shft_seq_ctl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rstn;
  logic          load;
  logic [W-1:0]  LD;
  logic          start;
  logic          dir;
  logic [1:0]    mode;
  logic [CW-1:0] amt;
  logic          sin;
  logic [W-1:0]  q;
  logic          cout;
  logic          busy;
  logic          done;

  shft_seq_ctl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .LD    (LD),
    .start (start),
    .dir   (dir),
    .mode  (mode),
    .amt   (amt),
    .sin   (sin),
    .q     (q),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  logic m_cout;  // model of cout across loads/aborts

  task automatic model(input logic [W-1:0] qi, input logic ci, input logic d,
                       input logic [1:0] m, input int n, input logic s,
                       output logic [W-1:0] qo, output logic co);
    logic f;
    qo = qi;
    co = ci;
    for (int i = 0; i < n; i++) begin
      if (d) begin
        co = qo[0];
        case (m)
          2'b00: f = 1'b0;
          2'b01: f = qo[W-1];
          2'b10: f = co;
          default: f = s;
        endcase
        qo = (qo >> 1) | ({{(W-1){1'b0}}, f} << (W-1));
      end else begin
        co = qo[W-1];
        case (m)
          2'b00, 2'b01: f = 1'b0;
          2'b10: f = co;
          default: f = s;
        endcase
        qo = (qo << 1) | {{(W-1){1'b0}}, f};
      end
    end
  endtask

  // Load ld, then start a burst. If disturb>0, pulse start again (with other
  // dir/mode/amt) at that busy cycle; it must be ignored.
  task automatic do_burst(input logic [W-1:0] ld, input logic d, input logic [1:0] m,
                          input int a, input logic s, input int disturb, input string nm);
    exp_t e;
    exp_t got;
    int   cyc;
    logic done_while_busy;
    @(negedge clk);
    load = 1'b1; LD = ld; start = 1'b0;
    @(negedge clk);
    load = 1'b0; start = 1'b1; dir = d; mode = m; amt = CW'(a); sin = s;
    model(ld, m_cout, d, m, a, s, e.q, e.c);
    m_cout = e.c;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    done_while_busy = 1'b0;
    while (busy && cyc < 40) begin
      cyc++;
      if (done) done_while_busy = 1'b1;
      if (cyc == disturb) begin
        start = 1'b1; dir = ~d; mode = ~m; amt = CW'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (cyc !== a) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", nm, cyc, a);
    end
    n_vec++;
    if (done_while_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_during_busy: got 1 expected 0", nm);
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_pulse: got %b expected 1", nm, done);
    end
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard_empty", nm);
    end else begin
      got = sb.pop_front();
      n_vec++;
      if (q !== got.q || cout !== got.c) begin
        n_err++;
        $display("FAIL %s result: got q=%h cout=%b expected q=%h cout=%b",
                 nm, q, cout, got.q, got.c);
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; load = 1'b0; LD = '0; start = 1'b0; dir = 1'b0;
    mode = 2'b00; amt = '0; sin = 1'b0;
    m_cout = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (q !== '0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got q=%h cout=%b busy=%b done=%b expected all 0", q, cout, busy, done);
    end
    rstn = 1'b1;
  endtask

  task automatic test_bursts();
    do_burst(8'hA5, 1'b1, 2'b00, 3, 1'b0, 0, "right_logical");    // 14 / 1
    do_burst(8'h90, 1'b1, 2'b01, 2, 1'b0, 0, "right_arith");      // E4 / 0
    do_burst(8'h3C, 1'b0, 2'b10, 4, 1'b0, 0, "left_rotate");      // C3 / 1
    do_burst(8'h00, 1'b0, 2'b11, 8, 1'b1, 0, "left_serial");      // FF / 0
    do_burst(8'h81, 1'b0, 2'b01, 1, 1'b0, 0, "left_arith");       // 02 / 1
    do_burst(8'h3C, 1'b1, 2'b10, 11, 1'b0, 0, "rotate_over_w");
    do_burst(8'hC3, 1'b1, 2'b01, 15, 1'b0, 0, "arith_over_w");
    do_burst(8'hB7, 1'b0, 2'b00, 15, 1'b0, 0, "logical_over_w");
    do_burst(8'h5A, 1'b1, 2'b11, 5, 1'b1, 0, "right_serial");
  endtask

  task automatic test_amt_zero();
    do_burst(8'h00, 1'b0, 2'b11, 8, 1'b1, 0, "serial_fill");
    do_burst(8'hFF, 1'b0, 2'b00, 0, 1'b0, 0, "amt_zero");
  endtask

  task automatic test_back_to_back();
    do_burst(8'hE1, 1'b1, 2'b00, 6, 1'b0, 2, "start_while_busy");
    do_burst(8'h0F, 1'b0, 2'b10, 6, 1'b0, 0, "back_to_back");
  endtask

  task automatic test_abort();
    int   cyc;
    logic seen;
    @(negedge clk);
    load = 1'b1; LD = 8'h11;
    @(negedge clk);
    load = 1'b0; start = 1'b1; dir = 1'b0; mode = 2'b00; amt = CW'(6);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 3 && busy) begin
      @(negedge clk);
      cyc++;
    end
    load = 1'b1; LD = 8'h5A;
    @(negedge clk);
    load = 1'b0;
    n_vec++;
    if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort: got q=%h busy=%b done=%b expected q=5a busy=0 done=0", q, busy, done);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || q !== 8'h5A) begin
      n_err++;
      $display("FAIL abort_quiet: got stray=%b q=%h expected stray=0 q=5a", seen, q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load = 1'b1; LD = 8'hF3;
    @(negedge clk);
    load = 1'b0; start = 1'b1; dir = 1'b1; mode = 2'b10; amt = CW'(6);
    repeat (3) @(negedge clk) start = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (q !== '0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got q=%h cout=%b busy=%b done=%b expected all 0", q, cout, busy, done);
    end
    m_cout = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    do_burst(8'h81, 1'b1, 2'b00, 1, 1'b0, 0, "rst_recover");      // 40 / 1
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_bursts();
    test_amt_zero();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
